clk_div_meter: RTL and testbench

//  Downstream checker for the odd/even clock dividers. Samples a divided clock (sig_in) in
//  the clk_in domain and measures its period and high time in clk_in cycles. Declares lock

---
 rtl/clk_div_meter_if.sv | 24 ++
 rtl/clk_div_meter.sv | 146 ++++++++++++++
 tb/tb_clk_div_meter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_meter_if.sv
// Bus bundle for clk_div_meter: measurement controls in, measurement results out.
interface clk_div_meter_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             period_err;
  logic             timeout;

  modport master (
    output en, sig_in, exp_period,
    input  period, high_time, meas_valid, locked, period_err, timeout
  );

  modport slave (
    input  en, sig_in, exp_period,
    output period, high_time, meas_valid, locked, period_err, timeout
  );
endinterface

// File: rtl/clk_div_meter.sv
// Divided-clock monitor: synchronizes sig_in into the clk_in domain, measures
// period (rise to rise) and high time (rise to fall) in clk_in cycles, declares
// lock after LOCK_CNT consecutive periods equal to exp_period, and flags a
// stalled input when the cycle counter saturates without a rising edge.
//
// state  | meaning
// IDLE   | en low; counters, lock and timeout cleared, results held
// ARM    | waiting for a rising edge to start timing (that edge is not measured)
// MEAS   | measuring, fewer than LOCK_CNT consecutive matches
// LOCKED | measuring, LOCK_CNT consecutive matches with no error since
module clk_div_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  clk_div_meter_if.slave   bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic                   s, rise, fall;
  logic [CNT_W-1:0]       cnt_q;
  logic [MW-1:0]          match_q, match_inc;
  logic                   is_match, hit_lock;
  logic                   arm_rise, take_high, take_meas, tmo;
  logic [CNT_W-1:0]       period_q, high_q;
  logic                   meas_valid_q, locked_q, period_err_q, timeout_q;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_d;
  assign fall      = ~s & s_d;
  assign is_match  = (cnt_q == bus.exp_period);
  assign match_inc = (match_q == LOCK_M) ? match_q : match_q + 1'b1;
  assign hit_lock  = (match_inc == LOCK_M);

  // Input synchronizer plus one extra flop for edge detection.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      s_d    <= s;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle strobes; everything is gated by en so a
  // deassert discards whatever was in flight.
  always_comb begin
    state_d   = state_q;
    arm_rise  = 1'b0;
    take_high = 1'b0;
    take_meas = 1'b0;
    tmo       = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            arm_rise = 1'b1;
            state_d  = MEAS;
          end
        end
        MEAS, LOCKED: begin
          take_high = fall;
          if (rise) begin
            take_meas = 1'b1;
            if (!is_match)    state_d = MEAS;
            else if (hit_lock) state_d = LOCKED;
          end else if (cnt_q == '1) begin
            tmo     = 1'b1;
            state_d = ARM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Cycle counter, results, match tracking and status flags.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      match_q      <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q     <= '0;
        match_q   <= '0;
        locked_q  <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        if (rise)               cnt_q <= CNT_W'(1);
        else if (cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
        if (arm_rise) timeout_q <= 1'b0;
        if (take_high) high_q <= cnt_q;
        if (take_meas) begin
          period_q     <= cnt_q;
          meas_valid_q <= 1'b1;
          if (is_match) begin
            match_q <= match_inc;
            if (hit_lock) locked_q <= 1'b1;
          end else begin
            match_q      <= '0;
            locked_q     <= 1'b0;
            period_err_q <= 1'b1;
          end
        end
        if (tmo) begin
          timeout_q <= 1'b1;
          locked_q  <= 1'b0;
          match_q   <= '0;
        end
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.period_err = period_err_q;
  assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: a 16-bit instance for the main checks and a
// 4-bit instance for the stall/timeout case, both watching the same sig_in.
module tb_clk_div_meter;
  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  logic sig    = 1'b0;

  always #5 clk_in = ~clk_in;

  clk_div_meter_if #(.CNT_W(16)) bus ();
  clk_div_meter_if #(.CNT_W(4))  bus4 ();

  assign bus.sig_in  = sig;
  assign bus4.sig_in = sig;

  clk_div_meter #(.CNT_W(16), .SYNC_STAGES(2), .LOCK_CNT(4)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  clk_div_meter #(.CNT_W(4), .SYNC_STAGES(2), .LOCK_CNT(4)) dut4 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus4)
  );

  int n_cmp = 0;
  int n_err = 0;

  // sig_in generator: high/low times in time units (clk period 10); a new
  // shape takes effect at the start of the next period.
  bit gen_on = 1'b0;
  int gen_hi = 30;
  int gen_lo = 20;

  initial begin : gen_blk
    int h;
    int l;
    forever begin
      if (gen_on) begin
        h = gen_hi;
        l = gen_lo;
        sig = 1'b1;
        #(h);
        sig = 1'b0;
        #(l);
      end else begin
        sig = 1'b0;
        wait (gen_on);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return bus.meas_valid;
      1: return bus4.meas_valid;
      2: return bus.locked;
      3: return bus4.timeout;
      4: return !bus4.timeout;
      5: return bus4.locked;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_on(input string tag, input int which, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk_in);
      cycles++;
    end while (!cond(which) && cycles < limit);
    n_cmp++;
    assert (cond(which))
    else begin
      n_err++;
      $error("FAIL %s: observed no event in %0d cycles expected event", tag, limit);
    end
  endtask

  task automatic start_gen();
    @(posedge clk_in);
    #2;
    gen_on = 1'b1;
  endtask

  initial begin : main
    int cyc;
    int pulses;
    bus.en = 1'b0;
    bus.exp_period = '0;
    bus4.en = 1'b0;
    bus4.exp_period = '0;

    // 1: reset held with sig toggling, then idle with en low
    start_gen();
    repeat (12) @(negedge clk_in);
    check("rst_period",     bus.period,     0);
    check("rst_high_time",  bus.high_time,  0);
    check("rst_meas_valid", bus.meas_valid, 0);
    check("rst_locked",     bus.locked,     0);
    check("rst_period_err", bus.period_err, 0);
    check("rst_timeout",    bus.timeout,    0);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (bus.meas_valid) pulses++;
    end
    check("idle_no_meas", pulses, 0);
    check("idle_locked", bus.locked, 0);

    // 2: 3 high / 2 low, expected period 5
    bus.exp_period = 16'd5;
    bus.en = 1'b1;
    wait_on("t2_m1", 0, 100, cyc);
    check("t2_m1_period", bus.period, 5);
    check("t2_m1_high", bus.high_time, 3);
    check("t2_m1_err", bus.period_err, 0);
    check("t2_m1_locked", bus.locked, 0);
    for (int i = 2; i <= 3; i++) begin
      wait_on("t2_mn", 0, 50, cyc);
      check("t2_mn_locked", bus.locked, 0);
      check("t2_mn_err", bus.period_err, 0);
    end
    wait_on("t2_m4", 0, 50, cyc);
    check("t2_m4_period", bus.period, 5);
    check("t2_m4_locked", bus.locked, 1);
    check("t2_m4_err", bus.period_err, 0);

    // 3: switch to 4 high / 3 low while locked
    gen_hi = 40;
    gen_lo = 30;
    wait_on("t3_last5", 0, 50, cyc);
    check("t3_last5_period", bus.period, 5);
    check("t3_last5_locked", bus.locked, 1);
    wait_on("t3_mis", 0, 50, cyc);
    check("t3_mis_period", bus.period, 7);
    check("t3_mis_err", bus.period_err, 1);
    check("t3_mis_locked", bus.locked, 0);
    bus.exp_period = 16'd7;
    for (int i = 1; i <= 3; i++) begin
      wait_on("t3_rl", 0, 50, cyc);
      check("t3_rl_period", bus.period, 7);
      check("t3_rl_locked", bus.locked, 0);
      check("t3_rl_err", bus.period_err, 0);
    end
    wait_on("t3_rl4", 0, 50, cyc);
    check("t3_rl4_locked", bus.locked, 1);
    check("t3_rl4_high", bus.high_time, 4);
    check("t3_rl4_err", bus.period_err, 0);

    // 4: 4-bit counter instance, stall the input
    bus4.exp_period = 4'd7;
    bus4.en = 1'b1;
    wait_on("t4_lock", 5, 200, cyc);
    check("t4_lock_period", bus4.period, 7);
    gen_on = 1'b0;
    wait_on("t4_to", 3, 60, cyc);
    check("t4_to_timeout", bus4.timeout, 1);
    check("t4_to_locked", bus4.locked, 0);
    start_gen();
    wait_on("t4_to_clr", 4, 60, cyc);
    check("t4_clr_no_meas", bus4.meas_valid, 0);
    wait_on("t4_first", 1, 60, cyc);
    check("t4_first_delay", cyc, 7);
    check("t4_first_period", bus4.period, 7);
    check("t4_first_locked", bus4.locked, 0);

    // 5: reset pulse mid-period while locked
    wait_on("t5_lock", 2, 300, cyc);
    wait_on("t5_meas", 0, 50, cyc);
    repeat (2) @(negedge clk_in);
    #1 reset = 1'b0;
    #1;
    check("t5_rst_period", bus.period, 0);
    check("t5_rst_high", bus.high_time, 0);
    check("t5_rst_locked", bus.locked, 0);
    check("t5_rst_meas", bus.meas_valid, 0);
    check("t5_rst_err", bus.period_err, 0);
    check("t5_rst_timeout", bus.timeout, 0);
    @(negedge clk_in);
    reset = 1'b1;
    wait_on("t5_first", 0, 100, cyc);
    check("t5_first_period", bus.period, 7);
    check("t5_first_high", bus.high_time, 4);
    check("t5_first_locked", bus.locked, 0);

    // 6: odd divide-by-5 with 50% duty (2.5 cycles high, 2.5 low)
    gen_on = 1'b0;
    repeat (20) @(negedge clk_in);
    bus.en = 1'b0;
    bus4.en = 1'b0;
    gen_hi = 25;
    gen_lo = 25;
    bus.exp_period = 16'd5;
    @(negedge clk_in);
    bus.en = 1'b1;
    repeat (3) @(negedge clk_in);
    start_gen();
    for (int i = 1; i <= 4; i++) begin
      wait_on("t6_meas", 0, 50, cyc);
      check("t6_period", bus.period, 5);
      check("t6_high_2or3", (bus.high_time == 16'd2) || (bus.high_time == 16'd3), 1);
      check("t6_err", bus.period_err, 0);
      check("t6_locked", bus.locked, (i == 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
